// File: rtl/adc_pkg.sv
// Definitions shared by the dual-slope ADC core and its sample sequencer:
// the result width and the sequencer state encoding.
package adc_pkg;

  localparam int ADC_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BLANK,
    ST_WAIT,
    ST_HOLD
  } seq_state_t;

endpackage

// File: rtl/adc_avg_accum.sv
// Sums 2**AVG_LOG2 captured samples and produces their truncated mean as a
// one-cycle combinational strobe on the capture of the final sample.
module adc_avg_accum
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sample,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_result_valid,
  output logic [DATA_W-1:0] o_result
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_shifted;

  assign w_last         = (r_cnt == LAST_CNT);
  assign w_sum          = r_acc + ACC_W'(i_data);
  assign w_shifted      = w_sum >> AVG_LOG2;
  assign o_result_valid = i_sample & w_last;
  assign o_result       = w_shifted[DATA_W-1:0];

  // The final sample both completes the mean and restarts the group; an
  // abandoned partial group is discarded by i_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear || (i_sample && w_last)) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_sample) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces ADC conversions, captures results with a timeout guard, and hands
// averaged samples to the consumer through a one-deep valid/ready register.
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD   = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              timeout_err,
  output logic              overrun,
  input  logic              clear_err
);

  localparam int PER_W  = $clog2(PERIOD);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

  seq_state_t        r_state;
  logic              r_adc_start;
  logic [PER_W-1:0]  r_per_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0] r_avg_data;
  logic              r_avg_valid;
  logic              r_timeout_err;
  logic              r_overrun;

  logic              w_capture;
  logic              w_timeout;
  logic              w_conv_end;
  logic              w_period_up;
  logic              w_release;
  logic              w_to_idle;
  logic              w_to_start;
  logic              w_result_valid;
  logic [DATA_W-1:0] w_result;
  logic              w_load;

  assign w_capture   = (r_state == ST_WAIT) && adc_done;
  assign w_timeout   = (r_state == ST_WAIT) && !adc_done && (r_wait_cnt == WAIT_LAST);
  assign w_conv_end  = w_capture || w_timeout;
  assign w_period_up = (r_per_cnt == PER_LAST);
  // A finished conversion may go straight to the next START when it already
  // outlasted the period, so no HOLD cycle is wasted.
  assign w_release   = w_conv_end || (r_state == ST_HOLD);
  assign w_to_idle   = w_release && !enable;
  assign w_to_start  = ((r_state == ST_IDLE) && enable) ||
                       (w_release && enable && w_period_up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_adc_start <= 1'b0;
      r_per_cnt   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_adc_start <= w_to_start;
      if (w_to_start) begin
        r_per_cnt <= '0;
      end else if (!w_period_up) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_START;
        end
        ST_START: begin
          r_state <= ST_BLANK;
        end
        ST_BLANK: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_to_idle)       r_state <= ST_IDLE;
          else if (w_to_start) r_state <= ST_START;
          else if (w_conv_end) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_to_idle)       r_state <= ST_IDLE;
          else if (w_to_start) r_state <= ST_START;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  adc_avg_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample       (w_capture),
    .i_data         (adc_data),
    .i_clear        (w_to_idle),
    .o_result_valid (w_result_valid),
    .o_result       (w_result)
  );

  assign w_load = w_result_valid && (!r_avg_valid || avg_ready);

  // Error flags: a new event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg_data    <= '0;
      r_avg_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_load) begin
        r_avg_data  <= w_result;
        r_avg_valid <= 1'b1;
      end else if (r_avg_valid && avg_ready) begin
        r_avg_valid <= 1'b0;
      end
      if (w_result_valid && r_avg_valid && !avg_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clear_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign adc_start   = r_adc_start;
  assign avg_data    = r_avg_data;
  assign avg_valid   = r_avg_valid;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;

endmodule
